// File: rtl/pc_fetch_ctrl.sv
// Program-counter and instruction-fetch controller feeding the 2:1 next-PC mux.
// Owns the PC, the pending-branch latch and the req/ack fetch handshake, and
// hands one fetched instruction at a time to decode.
module pc_fetch_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'd2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  input  logic        stall,
  output logic [15:0] pc,
  output logic [15:0] pc_plus,
  output logic [15:0] target_q,
  output logic        pc_next_sel,
  input  logic [15:0] next_pc,
  output logic [15:0] instr_out,
  output logic        instr_valid
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t        state, state_nxt;
  logic          br_pend, br_pend_nxt;
  logic [AW-1:0] pc_nxt, target_nxt, redirect;
  logic [DW-1:0] instr_nxt;
  logic          valid_nxt, req_nxt, flush;

  // Mux-side views of the PC and the pending-branch select
  assign pc_plus     = AW'(pc + PC_STEP);
  assign imem_addr   = pc;
  assign pc_next_sel = br_pend;

  // A branch arriving this cycle overrides any older latched target
  assign flush    = br_pend | branch_taken;
  assign redirect = branch_taken ? branch_target : target_q;

  // State and datapath registers; reset also drops the request immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      target_q    <= '0;
      br_pend     <= 1'b0;
      imem_req    <= 1'b0;
      instr_out   <= '0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      target_q    <= target_nxt;
      br_pend     <= br_pend_nxt;
      imem_req    <= req_nxt;
      instr_out   <= instr_nxt;
      instr_valid <= valid_nxt;
    end
  end

  // Next-state, PC update, branch latch and decode handoff
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    instr_nxt   = instr_out;
    valid_nxt   = instr_valid;
    target_nxt  = branch_taken ? branch_target : target_q;
    br_pend_nxt = br_pend | branch_taken;

    case (state)
      IDLE: begin
        valid_nxt = 1'b0;
        state_nxt = REQ;
      end
      REQ, WAIT: begin
        if (imem_ack) begin
          if (flush) begin
            valid_nxt   = 1'b0;
            pc_nxt      = redirect;
            br_pend_nxt = 1'b0;
            state_nxt   = REQ;
          end else begin
            instr_nxt = imem_data;
            valid_nxt = 1'b1;
            if (stall) begin
              state_nxt = HOLD;
            end else begin
              pc_nxt    = next_pc;
              state_nxt = REQ;
            end
          end
        end else begin
          valid_nxt = 1'b0;
          state_nxt = WAIT;
        end
      end
      HOLD: begin
        if (flush) begin
          valid_nxt   = 1'b0;
          pc_nxt      = redirect;
          br_pend_nxt = 1'b0;
          state_nxt   = REQ;
        end else if (!stall) begin
          valid_nxt = 1'b0;
          pc_nxt    = next_pc;
          state_nxt = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase

    req_nxt = (state_nxt == REQ) || (state_nxt == WAIT);
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios plus randomized traffic checked
// against a transaction-level reference model of the fetch controller.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        stall;

  logic [15:0] imem_addr, pc, pc_plus, target_q, next_pc, instr_out;
  logic        imem_req, pc_next_sel, instr_valid;

  logic [15:0] imem_addr_w, pc_w, pc_plus_w, target_q_w, next_pc_w, instr_out_w;
  logic        imem_req_w, pc_next_sel_w, instr_valid_w;

  int errors = 0;
  int checks = 0;

  // Reference model: phase 0 = post-reset bubble, 1 = fetching, 2 = holding for decode
  int          m_phase;
  logic [15:0] m_pc, m_tq, m_instr;
  logic        m_pend, m_valid;

  always #5 clk = ~clk;

  // External 2:1 next-PC mux around each instance
  assign next_pc   = pc_next_sel   ? target_q   : pc_plus;
  assign next_pc_w = pc_next_sel_w ? target_q_w : pc_plus_w;

  pc_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_ack(imem_ack), .imem_data(imem_data), .branch_taken(branch_taken),
    .branch_target(branch_target), .stall(stall), .pc(pc), .pc_plus(pc_plus),
    .target_q(target_q), .pc_next_sel(pc_next_sel), .next_pc(next_pc),
    .instr_out(instr_out), .instr_valid(instr_valid)
  );

  pc_fetch_ctrl #(.RESET_PC(16'hFFFE)) dut_w (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr_w), .imem_req(imem_req_w),
    .imem_ack(imem_ack), .imem_data(imem_data), .branch_taken(branch_taken),
    .branch_target(branch_target), .stall(stall), .pc(pc_w), .pc_plus(pc_plus_w),
    .target_q(target_q_w), .pc_next_sel(pc_next_sel_w), .next_pc(next_pc_w),
    .instr_out(instr_out_w), .instr_valid(instr_valid_w)
  );

  function automatic void model_reset();
    m_phase = 0;
    m_pc    = 16'h0000;
    m_tq    = 16'h0000;
    m_instr = 16'h0000;
    m_pend  = 1'b0;
    m_valid = 1'b0;
  endfunction

  // One clock of fetch behaviour stated as transaction rules
  function automatic void model_step(input logic ack, input logic [15:0] data,
                                     input logic bt, input logic [15:0] btgt,
                                     input logic stl);
    logic [15:0] dest;
    logic        redirect;
    dest     = bt ? btgt : m_tq;
    redirect = m_pend || bt;
    if (bt) begin
      m_tq   = btgt;
      m_pend = 1'b1;
    end
    if (m_phase == 0) begin
      m_valid = 1'b0;
      m_phase = 1;
    end else if (m_phase == 1) begin
      if (!ack) begin
        m_valid = 1'b0;
      end else if (redirect) begin
        m_valid = 1'b0;
        m_pc    = dest;
        m_pend  = 1'b0;
      end else begin
        m_instr = data;
        m_valid = 1'b1;
        if (stl) m_phase = 2;
        else     m_pc = m_pc + 16'd2;
      end
    end else begin
      if (redirect) begin
        m_valid = 1'b0;
        m_pc    = dest;
        m_pend  = 1'b0;
        m_phase = 1;
      end else if (!stl) begin
        m_valid = 1'b0;
        m_pc    = m_pc + 16'd2;
        m_phase = 1;
      end
    end
  endfunction

  // Apply one cycle of inputs, advance the model, sample just after the edge
  task automatic drive_cycle(input logic ack, input logic [15:0] data,
                             input logic bt, input logic [15:0] btgt,
                             input logic stl);
    imem_ack      = ack;
    imem_data     = data;
    branch_taken  = bt;
    branch_target = btgt;
    stall         = stl;
    model_step(ack, data, bt, btgt, stl);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    imem_ack = 1'b0; imem_data = '0; branch_taken = 1'b0;
    branch_target = '0; stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL reset_pc got %h want 0000", pc); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", imem_req); end
    checks++; if (instr_valid !== 1'b0 || instr_out !== 16'h0000) begin errors++; $display("FAIL reset_instr got %b/%h want 0/0000", instr_valid, instr_out); end
    checks++; if (target_q !== 16'h0000 || pc_next_sel !== 1'b0) begin errors++; $display("FAIL reset_br got %h/%b want 0000/0", target_q, pc_next_sel); end
    drive_cycle(1'b1, 16'hBEEF, 1'b0, 16'h0, 1'b0);
    checks++; if (imem_req !== 1'b1 || instr_valid !== 1'b0 || pc !== 16'h0000) begin errors++; $display("FAIL idle_bubble got req=%b v=%b pc=%h want 1/0/0000", imem_req, instr_valid, pc); end
  endtask

  task automatic test_sequential();
    logic [15:0] words [3];
    words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333;
    do_reset();
    drive_cycle(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL seq_addr0 got %h want 0000", imem_addr); end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, words[i], 1'b0, 16'h0, 1'b0);
      checks++;
      if (imem_addr !== 16'((i + 1) * 2) || instr_valid !== 1'b1 || instr_out !== words[i]) begin
        errors++;
        $display("FAIL seq_word%0d got addr=%h v=%b d=%h want %h/1/%h", i, imem_addr, instr_valid, instr_out, 16'((i + 1) * 2), words[i]);
      end
    end
    drive_cycle(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    checks++; if (instr_valid !== 1'b0 || pc !== 16'h0006) begin errors++; $display("FAIL seq_pulse got v=%b pc=%h want 0/0006", instr_valid, pc); end
  endtask

  task automatic test_wrap();
    do_reset();
    checks++; if (pc_w !== 16'hFFFE || pc_plus_w !== 16'h0000) begin errors++; $display("FAIL wrap_plus got pc=%h plus=%h want FFFE/0000", pc_w, pc_plus_w); end
    drive_cycle(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    drive_cycle(1'b1, 16'h7777, 1'b0, 16'h0, 1'b0);
    checks++; if (pc_w !== 16'h0000 || imem_addr_w !== 16'h0000 || instr_out_w !== 16'h7777) begin errors++; $display("FAIL wrap_pc got pc=%h d=%h want 0000/7777", pc_w, instr_out_w); end
  endtask

  task automatic test_stall();
    do_reset();
    drive_cycle(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    drive_cycle(1'b1, 16'hA5A5, 1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (instr_out !== 16'hA5A5 || instr_valid !== 1'b1 || pc !== 16'h0000 || imem_req !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold%0d got d=%h v=%b pc=%h req=%b want A5A5/1/0000/0", i, instr_out, instr_valid, pc, imem_req);
      end
      if (i < 2) drive_cycle(1'b1, 16'h5A5A, 1'b0, 16'h0, 1'b1);
    end
    drive_cycle(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    checks++; if (pc !== 16'h0002 || instr_valid !== 1'b0 || imem_req !== 1'b1) begin errors++; $display("FAIL stall_release got pc=%h v=%b req=%b want 0002/0/1", pc, instr_valid, imem_req); end
  endtask

  task automatic test_branch_wait();
    do_reset();
    drive_cycle(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    drive_cycle(1'b0, 16'h0, 1'b1, 16'h0100, 1'b0);
    checks++; if (pc_next_sel !== 1'b1 || target_q !== 16'h0100 || pc !== 16'h0000) begin errors++; $display("FAIL br_latch got sel=%b tq=%h pc=%h want 1/0100/0000", pc_next_sel, target_q, pc); end
    drive_cycle(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    checks++; if (pc_next_sel !== 1'b1 || imem_addr !== 16'h0000) begin errors++; $display("FAIL br_pending got sel=%b addr=%h want 1/0000", pc_next_sel, imem_addr); end
    drive_cycle(1'b1, 16'hDEAD, 1'b0, 16'h0, 1'b0);
    checks++; if (instr_valid !== 1'b0 || imem_addr !== 16'h0100 || pc_next_sel !== 1'b0) begin errors++; $display("FAIL br_flush got v=%b addr=%h sel=%b want 0/0100/0", instr_valid, imem_addr, pc_next_sel); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive_cycle(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    drive_cycle(1'b0, 16'h0, 1'b1, 16'h0200, 1'b0);
    drive_cycle(1'b0, 16'h0, 1'b1, 16'h0300, 1'b0);
    drive_cycle(1'b1, 16'hCAFE, 1'b0, 16'h0, 1'b0);
    checks++; if (imem_addr !== 16'h0300 || instr_valid !== 1'b0) begin errors++; $display("FAIL b2b_latest got addr=%h v=%b want 0300/0", imem_addr, instr_valid); end
    drive_cycle(1'b1, 16'h1234, 1'b0, 16'h0, 1'b1);
    checks++; if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL hold_entry got v=%b req=%b want 1/0", instr_valid, imem_req); end
    drive_cycle(1'b0, 16'h0, 1'b1, 16'h0400, 1'b1);
    checks++; if (instr_valid !== 1'b0 || pc !== 16'h0400 || imem_req !== 1'b1) begin errors++; $display("FAIL hold_branch got v=%b pc=%h req=%b want 0/0400/1", instr_valid, pc, imem_req); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive_cycle(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    drive_cycle(1'b1, 16'h4242, 1'b0, 16'h0, 1'b0);
    imem_ack = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 16'h0000) begin errors++; $display("FAIL rst_async got req=%b v=%b pc=%h want 0/0/0000", imem_req, instr_valid, pc); end
    @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
    drive_cycle(1'b1, 16'h9999, 1'b0, 16'h0, 1'b0);
    checks++; if (imem_req !== 1'b1 || instr_valid !== 1'b0 || pc !== 16'h0000) begin errors++; $display("FAIL rst_late_ack got req=%b v=%b pc=%h want 1/0/0000", imem_req, instr_valid, pc); end
  endtask

  task automatic test_random();
    logic        ack, bt, stl;
    logic [15:0] data, tgt;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      ack  = ($urandom_range(0, 99) < 55);
      bt   = ($urandom_range(0, 99) < 10);
      stl  = ($urandom_range(0, 99) < 30);
      data = 16'($urandom);
      tgt  = 16'($urandom) & 16'hFFFE;
      drive_cycle(ack, data, bt, tgt, stl);
      checks++;
      if (pc !== m_pc || imem_addr !== m_pc || pc_plus !== 16'(m_pc + 16'd2)) begin
        errors++;
        $display("FAIL rnd_pc cyc%0d got pc=%h addr=%h plus=%h want %h", n, pc, imem_addr, pc_plus, m_pc);
      end
      checks++;
      if (imem_req !== (m_phase == 1)) begin
        errors++;
        $display("FAIL rnd_req cyc%0d got %b want %b", n, imem_req, (m_phase == 1));
      end
      checks++;
      if (target_q !== m_tq || pc_next_sel !== m_pend) begin
        errors++;
        $display("FAIL rnd_br cyc%0d got tq=%h sel=%b want %h/%b", n, target_q, pc_next_sel, m_tq, m_pend);
      end
      checks++;
      if (instr_valid !== m_valid || instr_out !== m_instr) begin
        errors++;
        $display("FAIL rnd_instr cyc%0d got v=%b d=%h want %b/%h", n, instr_valid, instr_out, m_valid, m_instr);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    model_reset();
    test_reset();
    test_sequential();
    test_wrap();
    test_stall();
    test_branch_wait();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
